// File: rtl/imem_loader.sv
// imem_loader: boot loader that assembles a big-endian byte stream into instruction-memory words and holds the core in reset until done; define IMEM_LOADER_CSUM_EN for a trailing XOR checksum byte
module imem_loader #(
  parameter int ADDR_W = 9,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err
);
`ifdef IMEM_LOADER_CSUM_EN
  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR} state_t;
  logic [7:0] csum_q;
`else
  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, DONE, ERR} state_t;
`endif
  localparam logic [31:0] LIMIT = 32'((1 << ADDR_W) - BASE_ADDR);
  state_t            state_q;
  logic [15:0]       n_q;
  logic [23:0]       asm_q;
  logic [1:0]        bcnt_q;
  logic [ADDR_W-1:0] widx_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              core_rst_q;
  logic              load_done_q;
  logic              load_err_q;
  logic              acc;
  logic [15:0]       n_hdr;
  logic              last_word;
  assign in_ready   = (state_q != DONE) && (state_q != ERR);
  assign acc        = in_valid && in_ready;
  assign n_hdr      = {n_q[15:8], in_data};
  assign last_word  = 16'(widx_q) == n_q - 16'd1;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  // Loader FSM: header parse, word assembly and write strobe, completion/error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HDR_HI;
      n_q          <= '0;
      asm_q        <= '0;
      bcnt_q       <= '0;
      widx_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      imem_we_q <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      if (acc) csum_q <= csum_q ^ in_data;
`endif
      case (state_q)
        HDR_HI: if (acc) begin
          n_q[15:8] <= in_data;
          state_q   <= HDR_LO;
        end
        HDR_LO: if (acc) begin
          n_q <= n_hdr;
          if (32'(n_hdr) > LIMIT) begin
            state_q    <= ERR;
            load_err_q <= 1'b1;
          end else if (n_hdr == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_q     <= CSUM;
`else
            state_q     <= DONE;
            load_done_q <= 1'b1;
            core_rst_q  <= 1'b0;
`endif
          end else begin
            state_q <= DATA;
          end
        end
        DATA: if (acc) begin
          bcnt_q <= bcnt_q + 2'd1;
          asm_q  <= {asm_q[15:0], in_data};
          if (bcnt_q == 2'd3) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= ADDR_W'(BASE_ADDR) + widx_q;
            imem_wdata_q <= {asm_q, in_data};
            widx_q       <= widx_q + 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
            if (last_word) state_q <= CSUM;
`else
            if (last_word) state_q <= DONE;
`endif
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        CSUM: if (acc) begin
          if (csum_q == in_data) begin
            state_q     <= DONE;
            load_done_q <= 1'b1;
            core_rst_q  <= 1'b0;
          end else begin
            state_q    <= ERR;
            load_err_q <= 1'b1;
          end
        end
`endif
        DONE, ERR: if (start) begin
          state_q     <= HDR_HI;
          core_rst_q  <= 1'b1;
          load_done_q <= 1'b0;
          load_err_q  <= 1'b0;
          widx_q      <= '0;
          bcnt_q      <= '0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_q      <= '0;
`endif
        end else if (state_q == DONE && !load_done_q) begin
          // payload path: flag completion the cycle after the final write
          load_done_q <= 1'b1;
          core_rst_q  <= 1'b0;
        end
        default: state_q <= HDR_HI;
      endcase
    end
  end
endmodule
